// File: rtl/dot_product_acc.sv
// Dot-product sequencer/accumulator around an external combinational 8x8 multiplier.
// Optional saturating arithmetic with sticky out_ovf_o when DOT_PRODUCT_ACC_SAT_EN is defined.
module dot_product_acc #(
    parameter int LEN   = 8,
    parameter int ACC_W = 19,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_a_i,
    input  logic [7:0]       in_b_i,
    input  logic             in_last_i,
    output logic [7:0]       mul_a_o,
    output logic [7:0]       mul_b_o,
    input  logic [15:0]      mul_z_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_acc_o,
    output logic [CNT_W-1:0] out_count_o
`ifdef DOT_PRODUCT_ACC_SAT_EN
    ,
    output logic             out_ovf_o
`endif
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic             op_vld_q, op_vld_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             term_end_s;
    logic             handshake_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [ACC_W-1:0] sum_s;

`ifdef DOT_PRODUCT_ACC_SAT_EN
    logic             ovf_q, ovf_d;
    logic             out_ovf_q, out_ovf_d;
    logic [ACC_W:0]   sum_wide_s;
    logic             sat_s;

    // The carry out of the widened add means the true sum no longer fits: clamp to all-ones.
    assign sum_wide_s = {1'b0, acc_q} + (ACC_W + 1)'(mul_z_i);
    assign sat_s      = sum_wide_s[ACC_W];
    assign sum_s      = sat_s ? {ACC_W{1'b1}} : sum_wide_s[ACC_W-1:0];
`else
    assign sum_s      = acc_q + ACC_W'(mul_z_i);
`endif

    assign accept_s    = in_valid_i & in_ready_s;
    assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign term_end_s  = accept_s & (in_last_i | (cnt_inc_s == CNT_W'(LEN)));
    assign handshake_s = (state_q == ST_HOLD) & out_valid_q & out_ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (term_end_s)  state_d = ST_DRAIN; else state_d = ST_ACCUM;
            ST_DRAIN: state_d = ST_HOLD;
            ST_HOLD:  if (handshake_s) state_d = ST_ACCUM; else state_d = ST_HOLD;
            default:  state_d = ST_ACCUM;
        endcase
    end

    // FSM outputs: only ACCUM accepts operands, and never while reset is asserted
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_ACCUM: in_ready_s = rst_n_i;
            ST_DRAIN: in_ready_s = 1'b0;
            ST_HOLD:  in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
    end

    // Datapath next-state: operand capture, accumulation and result presentation
    always_comb begin
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        cnt_d       = cnt_q;
        op_vld_d    = 1'b0;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
`ifdef DOT_PRODUCT_ACC_SAT_EN
        ovf_d       = ovf_q;
        out_ovf_d   = out_ovf_q;
`endif
        if (accept_s) begin
            mul_a_d  = in_a_i;
            mul_b_d  = in_b_i;
            cnt_d    = cnt_inc_s;
            op_vld_d = 1'b1;
        end else begin
            op_vld_d = 1'b0;
        end
        if (op_vld_q) begin
            acc_d = sum_s;
`ifdef DOT_PRODUCT_ACC_SAT_EN
            ovf_d = ovf_q | sat_s;
`endif
        end else begin
            acc_d = acc_q;
        end
        // DRAIN folds in the final product, so the result is taken from the updated sum.
        if (state_q == ST_DRAIN) begin
            out_valid_d = 1'b1;
            out_acc_d   = acc_d;
            out_count_d = cnt_q;
`ifdef DOT_PRODUCT_ACC_SAT_EN
            out_ovf_d   = ovf_d;
`endif
        end else if (handshake_s) begin
            out_valid_d = 1'b0;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
`ifdef DOT_PRODUCT_ACC_SAT_EN
            ovf_d       = 1'b0;
            out_ovf_d   = 1'b0;
`endif
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers; reset discards any partial sum
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mul_a_q     <= 8'd0;
            mul_b_q     <= 8'd0;
            cnt_q       <= {CNT_W{1'b0}};
            op_vld_q    <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            out_acc_q   <= {ACC_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
`ifdef DOT_PRODUCT_ACC_SAT_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            cnt_q       <= cnt_d;
            op_vld_q    <= op_vld_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
`ifdef DOT_PRODUCT_ACC_SAT_EN
            ovf_q       <= ovf_d;
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign in_ready_o  = in_ready_s;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign out_valid_o = out_valid_q;
    assign out_acc_o   = out_acc_q;
    assign out_count_o = out_count_q;
`ifdef DOT_PRODUCT_ACC_SAT_EN
    assign out_ovf_o   = out_ovf_q;
`endif

endmodule
